// File: rtl/task_arbiter.sv
// Multi-tenant task arbiter: one holding slot per tree, round-robin issue
// into a shared downstream task FIFO.
module task_arbiter #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TREE_NUM-1:0]             req_valid,
  input  logic [TREE_NUM-1:0]             req_push,
  input  logic [TREE_NUM*PTW-1:0]         req_data,
  output logic [TREE_NUM-1:0]             req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [PTW+TREE_NUM_BITS:0]      fifo_din,
  output logic [31:0]                     issued_cnt
);

  localparam int IW = TREE_NUM_BITS + 1;

  logic [TREE_NUM-1:0]      pend_valid;
  logic [TREE_NUM-1:0]      pend_op;
  logic [PTW-1:0]           pend_data [TREE_NUM];
  logic [TREE_NUM_BITS-1:0] rr_ptr;
  logic [TREE_NUM_BITS-1:0] rr_nxt;
  logic [TREE_NUM-1:0]      grant;
  logic [TREE_NUM_BITS-1:0] gnt_idx;
  logic                     gnt_any;
  logic [IW-1:0]            scan;

  // Walk from rr_ptr with wrap; the first pending slot wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      scan = IW'(rr_ptr) + IW'(k);
      if (scan >= IW'(TREE_NUM)) begin
        scan = scan - IW'(TREE_NUM);
      end
      if (!gnt_any && !fifo_full && !rst &&
          pend_valid[scan[TREE_NUM_BITS-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[TREE_NUM_BITS-1:0];
        grant[scan[TREE_NUM_BITS-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (gnt_any) begin
      if (gnt_idx == TREE_NUM_BITS'(TREE_NUM - 1)) begin
        rr_nxt = '0;
      end else begin
        rr_nxt = gnt_idx + 1'b1;
      end
    end
  end

  assign req_ready  = ~pend_valid | grant;
  assign fifo_wr_en = gnt_any;

  always_comb begin
    fifo_din = '0;
    if (gnt_any) begin
      fifo_din = {pend_op[gnt_idx], gnt_idx, pend_data[gnt_idx]};
    end
  end

  // A slot granted and refilled in the same cycle keeps the new task.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= '0;
      pend_op    <= '0;
      rr_ptr     <= '0;
      issued_cnt <= '0;
      for (int i = 0; i < TREE_NUM; i++) begin
        pend_data[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_nxt;
      if (gnt_any) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      for (int i = 0; i < TREE_NUM; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          pend_valid[i] <= 1'b1;
          pend_op[i]    <= req_push[i];
          pend_data[i]  <= req_push[i] ? req_data[i*PTW +: PTW] : '0;
        end else if (grant[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_task_arbiter.sv
// Scoreboard bench for task_arbiter: expected task words are queued on
// acceptance and matched against every FIFO write.
module tb_task_arbiter;

  localparam int PTW = 16;
  localparam int TN  = 4;
  localparam int TB  = 2;
  localparam int DW  = PTW + TB + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [TN-1:0]     req_valid;
  logic [TN-1:0]     req_push;
  logic [TN*PTW-1:0] req_data;
  logic [TN-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic [31:0]       issued_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  task_arbiter #(.PTW(PTW), .TREE_NUM(TN), .TREE_NUM_BITS(TB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_push   (req_push),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .issued_cnt (issued_cnt)
  );

  function automatic logic [DW-1:0] word(input logic op, input int t,
                                         input logic [PTW-1:0] d);
    return {op, TB'(t), d};
  endfunction

  // Every FIFO write must match the oldest expected task.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %h, required no issue", fifo_din);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_din !== mon_exp) begin
          n_fail++;
          $display("FAIL issue_word: got %h, required %h", fifo_din, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_push = '0;
    req_data = '0;
    fifo_full = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr_en: got %b, required 0", fifo_wr_en);
    end
    n_checks++;
    if (fifo_din !== '0) begin
      n_fail++; $display("FAIL rst_din: got %h, required 0", fifo_din);
    end
    n_checks++;
    if (req_ready !== 4'hF) begin
      n_fail++; $display("FAIL rst_ready: got %b, required 1111", req_ready);
    end
    n_checks++;
    if (issued_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d, required 0", issued_cnt);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    req_valid = 4'b0100;
    req_push = 4'b0100;
    req_data[2*PTW +: PTW] = 16'h1234;
    exp_q.push_back(word(1'b1, 2, 16'h1234));
    @(negedge clk);
    n_checks++;
    if (req_ready[2] !== 1'b1) begin
      n_fail++; $display("FAIL push_ready: got %b, required 1", req_ready[2]);
    end
    n_checks++;
    if (fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL push_latency: got %b, required 0", fifo_wr_en);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL push_issue: got %b, required 1", fifo_wr_en);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (issued_cnt !== 32'd1) begin
      n_fail++; $display("FAIL push_cnt: got %0d, required 1", issued_cnt);
    end
    n_checks++;
    if (fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL push_once: got %b, required 0", fifo_wr_en);
    end
  endtask

  task automatic test_pop_zero();
    step();
    req_valid = 4'b0010;
    req_push = 4'b0000;
    req_data[1*PTW +: PTW] = 16'hFFFF;
    exp_q.push_back(word(1'b0, 1, 16'h0000));
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (fifo_din !== word(1'b0, 1, 16'h0000)) begin
      n_fail++; $display("FAIL pop_din: got %h, required %h",
                         fifo_din, word(1'b0, 1, 16'h0000));
    end
    step();
    @(negedge clk);
    n_checks++;
    if (issued_cnt !== 32'd2) begin
      n_fail++; $display("FAIL pop_cnt: got %0d, required 2", issued_cnt);
    end
  endtask

  task automatic test_round_robin();
    int seq [TN];
    logic [TN-1:0] exp_rdy;
    logic [PTW-1:0] d;
    step();
    do_reset();
    for (int t = 0; t < TN; t++) seq[t] = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = '1;
      req_push = '1;
      for (int t = 0; t < TN; t++) begin
        req_data[t*PTW +: PTW] = {4'(t), 12'(seq[t])};
      end
      exp_rdy = (c == 0) ? 4'hF : (TN'(1) << ((c - 1) % TN));
      for (int t = 0; t < TN; t++) begin
        if (exp_rdy[t]) begin
          d = {4'(t), 12'(seq[t])};
          exp_q.push_back(word(1'b1, t, d));
          seq[t]++;
        end
      end
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready c%0d: got %b, required %b",
                           c, req_ready, exp_rdy);
      end
      if (c > 0) begin
        n_checks++;
        if (fifo_wr_en !== 1'b1) begin
          n_fail++; $display("FAIL rr_wr_en c%0d: got %b, required 1",
                             c, fifo_wr_en);
        end
      end
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_push = 4'b0001;
    req_data[0 +: PTW] = 16'h0A0A;
    exp_q.push_back(word(1'b1, 0, 16'h0A0A));
    step();
    req_valid = '0;
    step();
    fifo_full = 1'b1;
    req_valid = '1;
    req_push = '1;
    for (int t = 0; t < TN; t++) req_data[t*PTW +: PTW] = 16'hF000 + 16'(t);
    for (int k = 1; k <= TN; k++) begin
      exp_q.push_back(word(1'b1, k % TN, 16'hF000 + 16'(k % TN)));
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'hF) begin
      n_fail++; $display("FAIL bp_fill: got %b, required 1111", req_ready);
    end
    step();
    for (int t = 0; t < TN; t++) req_data[t*PTW +: PTW] = 16'hBAD0 + 16'(t);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_wr_en c%0d: got %b, required 0", c, fifo_wr_en);
      end
      n_checks++;
      if (req_ready !== 4'h0) begin
        n_fail++; $display("FAIL bp_ready c%0d: got %b, required 0000", c, req_ready);
      end
      step();
    end
    fifo_full = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== 1'b1) begin
        n_fail++; $display("FAIL bp_resume c%0d: got %b, required 1", c, fifo_wr_en);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (issued_cnt !== 32'd5 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_cnt: got %0d (left %0d), required 5 (left 0)",
                         issued_cnt, exp_q.size());
    end
  endtask

  task automatic test_refill();
    step();
    do_reset();
    req_valid = 4'b1000;
    req_push = 4'b1001;
    req_data[3*PTW +: PTW] = 16'h3333;
    exp_q.push_back(word(1'b1, 3, 16'h3333));
    step();
    req_valid = 4'b1001;
    req_data[3*PTW +: PTW] = 16'h4444;
    req_data[0 +: PTW] = 16'h0101;
    exp_q.push_back(word(1'b1, 0, 16'h0101));
    exp_q.push_back(word(1'b1, 3, 16'h4444));
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'hF || fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL refill_ready: got %b/%b, required 1111/1",
                         req_ready, fifo_wr_en);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (fifo_din !== word(1'b1, 0, 16'h0101)) begin
      n_fail++; $display("FAIL refill_turn0: got %h, required %h",
                         fifo_din, word(1'b1, 0, 16'h0101));
    end
    step();
    @(negedge clk);
    n_checks++;
    if (fifo_din !== word(1'b1, 3, 16'h4444)) begin
      n_fail++; $display("FAIL refill_held: got %h, required %h",
                         fifo_din, word(1'b1, 3, 16'h4444));
    end
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL refill_lost: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fifo_full = 1'b1;
    req_valid = 4'b0111;
    req_push = 4'b0111;
    step();
    req_valid = '0;
    fifo_full = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_wr_en !== 1'b0 || fifo_din !== '0) begin
      n_fail++; $display("FAIL mrst_during: got %b/%h, required 0/0",
                         fifo_wr_en, fifo_din);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'hF) begin
        n_fail++; $display("FAIL mrst_after c%0d: got %b/%b, required 0/1111",
                           c, fifo_wr_en, req_ready);
      end
      step();
    end
    n_checks++;
    if (issued_cnt !== 32'd0) begin
      n_fail++; $display("FAIL mrst_cnt: got %0d, required 0", issued_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_pop_zero();
    test_round_robin();
    test_backpressure();
    test_refill();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/task_arbiter.md
TASK_ARBITER -- requirements
Module: task_arbiter

Interface
REQ-001 Parameter PTW, default 16: push payload width.
REQ-002 Parameter TREE_NUM, default 4: number of tenant trees, at least 2, need not be a power of two.
REQ-003 Parameter TREE_NUM_BITS, default $clog2(TREE_NUM): width of the tree-id field.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-006 Port req_valid, input, TREE_NUM bits: bit i high means tree i offers a task.
REQ-007 Port req_push, input, TREE_NUM bits: bit i high means push, low means pop.
REQ-008 Port req_data, input, TREE_NUM*PTW bits: slice [i*PTW +: PTW] is tree i's push payload.
REQ-009 Port req_ready, output, TREE_NUM bits: bit i high means tree i's offer is accepted this cycle.
REQ-010 Port fifo_full, input, 1 bit: downstream task FIFO is full.
REQ-011 Port fifo_wr_en, output, 1 bit: write strobe to the task FIFO.
REQ-012 Port fifo_din, output, PTW+TREE_NUM_BITS+1 bits: task word {op, tree_id, payload}.
REQ-013 Port issued_cnt, output, 32 bits: count of tasks written to the FIFO since reset.

Function
REQ-014 Each tree SHALL own a one-entry holding slot: pend_valid, pend_op, pend_data.
REQ-015 req_ready[i] SHALL equal !pend_valid[i] | grant[i], combinationally.
REQ-016 When req_valid[i] & req_ready[i], the slot SHALL load {req_push[i], req_data slice} on the next edge.
REQ-017 A pop SHALL load 0 into pend_data regardless of the req_data value.
REQ-018 The grant SHALL be combinational and one-hot or zero.
REQ-019 grant[i] SHALL be high only when !fifo_full and pend_valid[i] is high.
REQ-020 Among pending slots, grant SHALL go to the first one found searching i = rr_ptr, rr_ptr+1, ..., with wrap modulo TREE_NUM.
REQ-021 fifo_wr_en SHALL equal |grant.
REQ-022 fifo_din SHALL equal {pend_op[g], g[TREE_NUM_BITS-1:0], pend_data[g]} for the granted index g, and SHALL be 0 when no grant is made.
REQ-023 On a grant to g, rr_ptr SHALL become g+1, wrapping to 0 at TREE_NUM.
REQ-024 On a grant to g, pend_valid[g] SHALL clear, unless the slot is refilled in the same cycle (REQ-016), in which case the new task SHALL be held.
REQ-025 Latency: a task accepted at edge N SHALL assert fifo_wr_en no earlier than the cycle after edge N.
REQ-026 Throughput: at most one task SHALL be issued per cycle; with all trees pending, each tree SHALL be issued once per TREE_NUM cycles.
REQ-027 While fifo_full is high, there SHALL be no grant, no change to rr_ptr, and pending slots SHALL hold; trees with pend_valid set SHALL see req_ready low.
REQ-028 issued_cnt SHALL increment by 1 on each fifo_wr_en cycle and SHALL wrap from 2^32-1 to 0.
REQ-029 No task SHALL be duplicated, dropped, or reordered within a tree.

Reset
REQ-030 When rst is high at an edge, the block SHALL clear pend_valid, pend_op, pend_data, rr_ptr and issued_cnt to 0.
REQ-031 During rst, fifo_wr_en SHALL be 0, fifo_din SHALL be 0, and req_ready SHALL be all ones once the reset edge has occurred.
REQ-032 rst asserted mid-operation SHALL discard all held tasks, and no partial issue SHALL follow.

Verification
REQ-033 Single push: tree 2 push, data 0x1234, TREE_NUM=4, PTW=16 -> one cycle later fifo_wr_en=1 and fifo_din={1,2'd2,16'h1234}; issued_cnt=1.
REQ-034 Pop zeroing: tree 1 pop with req_data=0xFFFF -> fifo_din={0,2'd1,16'h0000}.
REQ-035 Round-robin: all 4 trees pending continuously -> issue order 0,1,2,3,0,...; each tree's req_ready is high exactly in its grant cycle.
REQ-036 Backpressure: all slots full, fifo_full=1 for 5 cycles -> fifo_wr_en=0, req_ready=0, and rr_ptr unchanged; after fifo_full drops, issue resumes at the previous rr_ptr.
REQ-037 Refill on grant: tree 3 granted while offering a new task in the same cycle -> the new task is held and issued on a later turn, and none is lost.
REQ-038 Mid-run reset: rst asserted with 3 slots pending -> no fifo_wr_en from the discarded tasks, and issued_cnt=0.
